// File: rtl/gpu_pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pll_ctrl_pkg
// Shared definitions for the GPU PLL reset controller:
//   - pll_state_e : sequencing states of the controller FSM
//   - DEF_*       : default parameter values for the controller
//   - cnt_width() : width of the shared cycle counter
// -----------------------------------------------------------------------------
package gpu_pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } pll_state_e;

   localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int unsigned DEF_MAX_RETRIES         = 3;

   // The counter only ever holds values up to (largest limit - 1), so
   // $clog2 of the largest limit is enough; keep at least one bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/gpu_pll_lock_sync.sv
// -----------------------------------------------------------------------------
// gpu_pll_lock_sync
// Two-flop synchronizer bringing the PLL's asynchronous locked flag into the
// reference clock domain. Both flops clear on the asynchronous reset.
// Ports:
//   clk     in  reference clock
//   rst     in  asynchronous active-high reset
//   async_i in  asynchronous level to synchronize
//   sync_o  out synchronized level (2 cycles of latency)
// -----------------------------------------------------------------------------
module gpu_pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/gpu_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// gpu_pll_reset_ctrl
// Sequences the GPU PLL: pulses the PLL reset, waits for lock (with timeout
// and bounded retries), requires lock to be stable before releasing the
// GPU-domain reset, and re-sequences on loss of lock.
// Optional feature macro: GPU_PLL_LOCK_LOSS_CNT_EN (counts RUN lock losses,
// saturating at 255; when undefined lock_loss_count_o is tied to 0).
// Ports:
//   clk                in  50 MHz reference clock
//   rst                in  asynchronous active-high reset
//   pll_locked_i       in  PLL locked flag (asynchronous to clk)
//   soft_reset_req_i   in  one-cycle request to re-sequence the PLL
//   pll_rst_o          out reset to the PLL, active-high
//   gpu_rst_o          out GPU-domain reset, active-high
//   ready_o            out lock stable and gpu_rst released
//   fault_o            out retries exhausted
//   retry_count_o      out failed attempts in the current sequence
//   lock_loss_count_o  out lock losses seen while running
// -----------------------------------------------------------------------------
module gpu_pll_reset_ctrl
   import gpu_pll_ctrl_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked_i,
   input  logic       soft_reset_req_i,
   output logic       pll_rst_o,
   output logic       gpu_rst_o,
   output logic       ready_o,
   output logic       fault_o,
   output logic [3:0] retry_count_o,
   output logic [7:0] lock_loss_count_o
);

   localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                          LOCK_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

   pll_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic [3:0]    retry_inc;
   logic          locked_s;
   logic          pll_rst_q, pll_rst_d;
   logic          gpu_rst_q, gpu_rst_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;

   gpu_pll_lock_sync u_lock_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (pll_locked_i),
      .sync_o  (locked_s)
   );

   assign retry_inc = retry_q + 4'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      // A re-sequence request overrides timeout and lock events this cycle.
      if (soft_reset_req_i) begin
         state_d = RESET_PLL;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            RESET_PLL: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  retry_d = retry_inc;
                  cnt_d   = '0;
                  state_d = (retry_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            STABLE: begin
               // Any low sample restarts both the timeout and the stability run.
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            RUN: begin
               cnt_d = '0;
               if (!locked_s) state_d = RESET_PLL;
            end
            FAULT: begin
               cnt_d = '0;
            end
            default: begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so the registered copies
      // line up with the state register.
      pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
      gpu_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         gpu_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         gpu_rst_q <= gpu_rst_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

`ifdef GPU_PLL_LOCK_LOSS_CNT_EN
   logic       lock_lost;
   logic [7:0] loss_q, loss_d;

   // Only a genuine lock drop in RUN counts; a soft request wins that cycle.
   assign lock_lost = (state_q == RUN) && !locked_s && !soft_reset_req_i;
   assign loss_d    = (lock_lost && (loss_q != 8'hFF)) ? loss_q + 8'd1 : loss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) loss_q <= '0;
      else     loss_q <= loss_d;
   end

   assign lock_loss_count_o = loss_q;
`else
   assign lock_loss_count_o = '0;
`endif

   assign pll_rst_o     = pll_rst_q;
   assign gpu_rst_o     = gpu_rst_q;
   assign ready_o       = ready_q;
   assign fault_o       = fault_q;
   assign retry_count_o = retry_q;

endmodule

// File: tb/tb_gpu_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpu_pll_reset_ctrl
// Directed bench for gpu_pll_reset_ctrl with small parameters. A phase-level
// model of the sequencer predicts all outputs every cycle; literal
// expectations at hand-computed cycles pin the model.
// -----------------------------------------------------------------------------
module tb_gpu_pll_reset_ctrl;

   localparam int RSTP = 4;
   localparam int STAB = 8;
   localparam int TOUT = 32;
   localparam int MAXR = 2;
`ifdef GPU_PLL_LOCK_LOSS_CNT_EN
   localparam int LOSS_EN = 1;
`else
   localparam int LOSS_EN = 0;
`endif

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       soft_reset_req;
   logic       pll_rst;
   logic       gpu_rst;
   logic       ready;
   logic       fault;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 0;

   gpu_pll_reset_ctrl #(
      .RST_PULSE_CYCLES    (RSTP),
      .LOCK_STABLE_CYCLES  (STAB),
      .LOCK_TIMEOUT_CYCLES (TOUT),
      .MAX_RETRIES         (MAXR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .pll_locked_i      (pll_locked),
      .soft_reset_req_i  (soft_reset_req),
      .pll_rst_o         (pll_rst),
      .gpu_rst_o         (gpu_rst),
      .ready_o           (ready),
      .fault_o           (fault),
      .retry_count_o     (retry_count),
      .lock_loss_count_o (lock_loss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- phase-level model ----------------
   localparam int PH_PULSE = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAULT = 4;
   int m_phase   = PH_PULSE;
   int m_done    = 0;   // cycles already spent in the current phase
   int m_retries = 0;
   int m_losses  = 0;
   bit m_seen1   = 0;   // pll_locked as sampled one edge ago
   bit m_seen2   = 0;   // pll_locked as sampled two edges ago (= locked_s)
   bit m_ls;
   int m_elapsed;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_phase = PH_PULSE; m_done = 0; m_retries = 0; m_losses = 0;
         m_seen1 = 0; m_seen2 = 0;
      end else begin
         m_ls      = m_seen2;
         m_elapsed = m_done + 1;
         m_seen2   = m_seen1;
         m_seen1   = pll_locked;
         m_done    = m_elapsed;
         if (soft_reset_req) begin
            m_phase = PH_PULSE; m_done = 0; m_retries = 0;
         end else if (m_phase == PH_PULSE) begin
            if (m_elapsed == RSTP) begin m_phase = PH_WAIT; m_done = 0; end
         end else if (m_phase == PH_WAIT) begin
            if (m_ls) begin
               m_phase = PH_STABLE; m_done = 0;
            end else if (m_elapsed == TOUT) begin
               m_retries = m_retries + 1;
               m_phase   = (m_retries == MAXR) ? PH_FAULT : PH_PULSE;
               m_done    = 0;
            end
         end else if (m_phase == PH_STABLE) begin
            if (!m_ls) begin
               m_phase = PH_WAIT; m_done = 0;
            end else if (m_elapsed == STAB) begin
               m_phase = PH_RUN; m_done = 0; m_retries = 0;
            end
         end else if (m_phase == PH_RUN) begin
            if (!m_ls) begin
               m_phase = PH_PULSE; m_done = 0;
               if (m_losses < 255) m_losses = m_losses + 1;
            end
         end
      end
   end

   function automatic logic [15:0] model_vec();
      logic [15:0] v;
      v[15]   = (m_phase == PH_PULSE) || (m_phase == PH_FAULT);
      v[14]   = (m_phase != PH_RUN);
      v[13]   = (m_phase == PH_RUN);
      v[12]   = (m_phase == PH_FAULT);
      v[11:8] = 4'(m_retries);
      v[7:0]  = (LOSS_EN != 0) ? 8'(m_losses) : 8'd0;
      return v;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         n_vec++;
         if ({pll_rst, gpu_rst, ready, fault, retry_count, lock_loss_count} !== model_vec()) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: dut=%h model=%h", $time,
                     {pll_rst, gpu_rst, ready, fault, retry_count, lock_loss_count}, model_vec());
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic soft_pulse();
      soft_reset_req = 1'b1;
      ticks(1);
      soft_reset_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;
      #1 rst = 1'b1;
      #1 cmp_en = 1'b1;
      ticks(3);
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_gpu_rst", gpu_rst, 1);
      chk("rst_ready", ready, 0);
      chk("rst_fault", fault, 0);
      chk("rst_retry", retry_count, 0);
      chk("rst_loss", lock_loss_count, 0);

      // Power-up: lock at cycle 10, ready at cycle 21.
      rst = 1'b0;                       // cycle 0
      ticks(3);  chk("pulse_c3", pll_rst, 1);
      ticks(1);  chk("pulse_c4", pll_rst, 0);
      ticks(6);  pll_locked = 1'b1;     // cycle 10
      ticks(10); chk("ready_c20", ready, 0);
      ticks(1);  chk("ready_c21", ready, 1);
      chk("gpu_rst_c21", gpu_rst, 0);
      chk("retry_c21", retry_count, 0);

      // Lock loss in RUN: outputs react 3 cycles after the drop.
      ticks(5);  pll_locked = 1'b0;     // cycle d
      ticks(2);  chk("loss_d2_ready", ready, 1);
      ticks(1);  chk("loss_d3_ready", ready, 0);
      chk("loss_d3_gpu_rst", gpu_rst, 1);
      chk("loss_d3_pll_rst", pll_rst, 1);
      ticks(3);  chk("loss_d6_pll_rst", pll_rst, 1);
      ticks(1);  chk("loss_d7_pll_rst", pll_rst, 0);
      chk("loss_count_1", lock_loss_count, LOSS_EN);

      // No lock: two timeouts lead to FAULT (soft request at cycle s).
      soft_pulse();                     // cycle s+1
      chk("to_s1_pll_rst", pll_rst, 1);
      ticks(35); chk("to_s36_retry", retry_count, 0);
      chk("to_s36_pll_rst", pll_rst, 0);
      ticks(1);  chk("to_s37_retry", retry_count, 1);
      chk("to_s37_pll_rst", pll_rst, 1);
      ticks(35); chk("to_s72_fault", fault, 0);
      ticks(1);  chk("to_s73_fault", fault, 1);
      chk("to_s73_retry", retry_count, 2);
      chk("to_s73_pll_rst", pll_rst, 1);
      ticks(10); chk("fault_held", fault, 1);
      chk("fault_held_pll_rst", pll_rst, 1);

      // Leave FAULT via soft request, then lock.
      soft_pulse();                     // cycle f+1
      chk("sr_fault", fault, 0);
      chk("sr_retry", retry_count, 0);
      chk("sr_pll_rst", pll_rst, 1);
      ticks(3);  chk("sr_f4_pll_rst", pll_rst, 1);
      ticks(1);  chk("sr_f5_pll_rst", pll_rst, 0);
      pll_locked = 1'b1;                // cycle r
      ticks(10); chk("sr_ready_r10", ready, 0);
      ticks(1);  chk("sr_ready_r11", ready, 1);

      // Glitch during STABLE at stable count 5 (soft request at cycle s).
      soft_pulse();                     // cycle s+1
      ticks(8);  pll_locked = 1'b0;     // cycle s+9
      ticks(1);  pll_locked = 1'b1;     // cycle s+10, re-rise
      ticks(4);  chk("gl_s14_ready", ready, 0);
      ticks(6);  chk("gl_s20_ready", ready, 0);
      ticks(1);  chk("gl_s21_ready", ready, 1);
      chk("gl_loss_unchanged", lock_loss_count, LOSS_EN);

      // Asynchronous reset while waiting with one failed attempt.
      pll_locked = 1'b0;
      soft_pulse();                     // cycle s+1
      ticks(40);                        // cycle s+41, WAIT_LOCK, retry 1
      chk("ar_pre_retry", retry_count, 1);
      chk("ar_pre_pll_rst", pll_rst, 0);
      #2 rst = 1'b1;
      #1;
      chk("ar_pll_rst", pll_rst, 1);
      chk("ar_gpu_rst", gpu_rst, 1);
      chk("ar_ready", ready, 0);
      chk("ar_fault", fault, 0);
      chk("ar_retry", retry_count, 0);
      chk("ar_loss", lock_loss_count, 0);

      // Repeated lock losses: counter saturates at 255.
      ticks(1);
      rst = 1'b0;
      pll_locked = 1'b1;
      ticks(20);
      chk("sat_pre_ready", ready, 1);
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         ticks(1);
         pll_locked = 1'b1;
         ticks(20);
      end
      chk("sat_ready", ready, 1);
      chk("sat_loss", lock_loss_count, (LOSS_EN != 0) ? 255 : 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
